radiant_event_hdr_gen: RTL and testbench

- Single-clock, parametrised event header generator.
- Timestamps accepted triggers from NUM_SRC masked sources against a CNT_W-bit clock counter and a 32-bit PPS second counter, with PPS-armed synchronous reset of all counters.
- Buffers DEPTH complete 8-word headers in an internal FIFO and streams them out one word per handshake.
- Adds per-source masking, a programmable trigger holdoff, counter widths above 32 bits, and counted (not corrupting) drops on overflow.

---
 rtl/radiant_event_pkg.sv | 40 ++++
 rtl/radiant_event_hdr_gen_fifo.sv | 63 ++++++
 rtl/radiant_event_hdr_gen.sv | 141 ++++++++++++++
 tb/tb_radiant_event_hdr_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radiant_event_pkg.sv
// Shared constants, status-field layout and header-entry type for the
// radiant event header generator.
package radiant_event_pkg;

  localparam logic [31:0] HDR_ID        = 32'h52444531;
  localparam int          NUM_HDR_WORDS = 8;

  localparam int ST_DROP_LSB = 16;
  localparam int ST_MASK_LSB = 8;
  localparam int ST_FIRST    = 1;
  localparam int ST_PPS      = 0;

  // Header words 1..7; word 0 is the constant HDR_ID and is never stored.
  typedef struct packed {
    logic [31:0] clk_hi;
    logic [31:0] last_pps;
    logic [31:0] status;
    logic [31:0] info;
    logic [31:0] clk_lo;
    logic [31:0] sec_cnt;
    logic [31:0] ev_cnt;
  } hdr_entry_t;

  function automatic logic [31:0] hdr_word(input hdr_entry_t e, input logic [2:0] idx);
    logic [31:0] w;
    w = HDR_ID;
    case (idx)
      3'd0: w = HDR_ID;
      3'd1: w = e.ev_cnt;
      3'd2: w = e.sec_cnt;
      3'd3: w = e.clk_lo;
      3'd4: w = e.info;
      3'd5: w = e.status;
      3'd6: w = e.last_pps;
      3'd7: w = e.clk_hi;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/radiant_event_hdr_gen_fifo.sv
// Header FIFO: DEPTH complete entries, read out one 32-bit word at a time.
// The entry is popped when its last word is consumed.
module radiant_hdr_fifo
  import radiant_event_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  hdr_entry_t             push_entry_i,
  input  logic                   rd_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            word_o,
  output logic                   last_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [2:0]  LAST_WORD = 3'(NUM_HDR_WORDS - 1);

  hdr_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [2:0]      word_idx;
  logic            do_push;
  logic            do_pop;
  logic            word_adv;

  assign full_o   = (count == (AW+1)'(DEPTH));
  assign empty_o  = (count == '0);
  assign count_o  = count;
  assign do_push  = push_i && !full_o;
  assign word_adv = rd_i && !empty_o;
  assign do_pop   = word_adv && (word_idx == LAST_WORD);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_idx <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      if (do_pop)        word_idx <= '0;
      else if (word_adv) word_idx <= word_idx + 3'd1;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say so.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_entry_i;
  end

  assign word_o = empty_o ? 32'd0 : hdr_word(mem[rd_ptr], word_idx);
  assign last_o = !empty_o && (word_idx == LAST_WORD);

endmodule

// File: rtl/radiant_event_hdr_gen.sv
// Event header generator: timestamps masked triggers against clock/PPS
// counters, queues 8-word headers and streams them out word by word.
module radiant_event_hdr_gen
  import radiant_event_pkg::*;
#(
  parameter int          NUM_SRC     = 4,
  parameter int          CNT_W       = 48,
  parameter int          DEPTH       = 16,
  parameter int          HOLDOFF_W   = 16,
  // clk_cnt value loaded by reset; 0 in normal use
  parameter logic [63:0] CNT_RST_VAL = 64'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   pps_i,
  input  logic                   sync_arm_i,
  input  logic [NUM_SRC-1:0]     trig_i,
  input  logic [NUM_SRC-1:0]     trig_en_i,
  input  logic [HOLDOFF_W-1:0]   holdoff_i,
  input  logic [31:0]            info_i,
  input  logic                   hdr_rd_i,
  output logic [31:0]            hdr_dat_o,
  output logic                   hdr_valid_o,
  output logic                   hdr_last_o,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic [15:0]            dropped_o,
  output logic                   sync_o,
  output logic [31:0]            sec_count_o
);

  logic [CNT_W-1:0]     clk_cnt;
  logic [31:0]          sec_cnt;
  logic [31:0]          ev_cnt;
  logic [31:0]          last_pps;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic [15:0]          dropped;
  logic [15:0]          since_drop;
  logic                 armed;
  logic                 seen_ev;
  logic                 sync_q;

  logic [NUM_SRC-1:0]   src_hit;
  logic                 hit;
  logic                 hold_zero;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 drop;
  logic                 do_sync;
  hdr_entry_t           entry;

  assign src_hit   = trig_i & trig_en_i;
  assign hit       = |src_hit;
  assign hold_zero = (hold_cnt == '0);
  // fifo_full reflects the registered count, so a same-cycle pop never frees room.
  assign accept    = hit && hold_zero && !fifo_full;
  assign drop      = hit && hold_zero && fifo_full;
  assign do_sync   = pps_i && armed;

  always_comb begin
    entry                              = '0;
    entry.ev_cnt                       = ev_cnt;
    entry.sec_cnt                      = sec_cnt;
    entry.clk_lo                       = clk_cnt[31:0];
    entry.info                         = info_i;
    entry.status[ST_DROP_LSB +: 16]    = since_drop;
    entry.status[ST_MASK_LSB +: 8]     = 8'(src_hit);
    entry.status[ST_FIRST]             = !seen_ev;
    entry.status[ST_PPS]               = pps_i;
    entry.last_pps                     = last_pps;
    entry.clk_hi                       = 32'(clk_cnt >> 32);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_cnt    <= CNT_W'(CNT_RST_VAL);
      sec_cnt    <= '0;
      ev_cnt     <= '0;
      last_pps   <= '0;
      hold_cnt   <= '0;
      dropped    <= '0;
      since_drop <= '0;
      armed      <= 1'b0;
      seen_ev    <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      clk_cnt <= clk_cnt + CNT_W'(1);
      sync_q  <= do_sync;

      if (accept)          hold_cnt <= holdoff_i;
      else if (!hold_zero) hold_cnt <= hold_cnt - HOLDOFF_W'(1);

      if (do_sync) begin
        clk_cnt    <= '0;
        sec_cnt    <= '0;
        ev_cnt     <= '0;
        last_pps   <= '0;
        dropped    <= '0;
        since_drop <= '0;
        seen_ev    <= 1'b0;
        armed      <= 1'b0;
      end else begin
        if (pps_i) begin
          sec_cnt  <= sec_cnt + 32'd1;
          last_pps <= clk_cnt[31:0];
        end
        if (accept) begin
          ev_cnt     <= ev_cnt + 32'd1;
          since_drop <= '0;
          seen_ev    <= 1'b1;
        end
        if (drop) begin
          if (dropped != 16'hFFFF)    dropped    <= dropped + 16'd1;
          if (since_drop != 16'hFFFF) since_drop <= since_drop + 16'd1;
        end
        if (sync_arm_i) armed <= 1'b1;
      end
    end
  end

  radiant_hdr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_i       (accept),
    .push_entry_i (entry),
    .rd_i         (hdr_rd_i),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (pending_o),
    .word_o       (hdr_dat_o),
    .last_o       (hdr_last_o)
  );

  assign hdr_valid_o = !fifo_empty;
  assign dropped_o   = dropped;
  assign sync_o      = sync_q;
  assign sec_count_o = sec_cnt;

endmodule

// File: tb/tb_radiant_event_hdr_gen.sv
// Bench for radiant_event_hdr_gen: directed steps plus a random phase,
// all checked each cycle against a queue-based header model.
module tb_radiant_event_hdr_gen;

  localparam int          DEPTH    = 16;
  localparam logic [63:0] W_PRESET = 64'h0000_0000_FFFF_FFFA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps = 1'b0;
  logic        sync_arm = 1'b0;
  logic [3:0]  trig = '0;
  logic [3:0]  trig_en = 4'hF;
  logic [15:0] holdoff = '0;
  logic [31:0] info = '0;
  logic        hdr_rd = 1'b0;
  logic [31:0] hdr_dat_o;
  logic        hdr_valid_o;
  logic        hdr_last_o;
  logic [4:0]  pending_o;
  logic [15:0] dropped_o;
  logic        sync_o;
  logic [31:0] sec_count_o;

  // second instance with clk_cnt preset just below 2^32
  logic [3:0]  w_trig = '0;
  logic        w_rd = 1'b0;
  logic        w_zero = 1'b0;
  logic [3:0]  w_en = 4'hF;
  logic [15:0] w_hold = '0;
  logic [31:0] w_info = 32'h0000_A5A5;
  logic [31:0] w_dat;
  logic        w_valid;
  logic        w_last;
  logic [4:0]  w_pending;
  logic [15:0] w_dropped;
  logic        w_sync;
  logic [31:0] w_sec;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [47:0] m_clk;
  logic [31:0] m_sec, m_ev, m_lpps;
  logic [15:0] m_hold, m_drop, m_since;
  logic        m_seen, m_armed, m_sync;
  int          m_w;
  logic [31:0] exp_q[$];

  logic [31:0] rd_words[8];
  logic        rd_last[8];
  logic [31:0] w3[3];
  logic [31:0] w_words[16];
  logic        w_lasts[16];
  logic [63:0] w_exp0, w_exp1;
  logic [31:0] saved_info, sec_before;

  radiant_event_hdr_gen #(
    .NUM_SRC(4), .CNT_W(48), .DEPTH(DEPTH), .HOLDOFF_W(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pps_i(pps), .sync_arm_i(sync_arm),
    .trig_i(trig), .trig_en_i(trig_en), .holdoff_i(holdoff), .info_i(info),
    .hdr_rd_i(hdr_rd), .hdr_dat_o(hdr_dat_o), .hdr_valid_o(hdr_valid_o),
    .hdr_last_o(hdr_last_o), .pending_o(pending_o), .dropped_o(dropped_o),
    .sync_o(sync_o), .sec_count_o(sec_count_o)
  );

  radiant_event_hdr_gen #(
    .NUM_SRC(4), .CNT_W(48), .DEPTH(DEPTH), .HOLDOFF_W(16), .CNT_RST_VAL(W_PRESET)
  ) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .pps_i(w_zero), .sync_arm_i(w_zero),
    .trig_i(w_trig), .trig_en_i(w_en), .holdoff_i(w_hold), .info_i(w_info),
    .hdr_rd_i(w_rd), .hdr_dat_o(w_dat), .hdr_valid_o(w_valid),
    .hdr_last_o(w_last), .pending_o(w_pending), .dropped_o(w_dropped),
    .sync_o(w_sync), .sec_count_o(w_sec)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clk = '0; m_sec = '0; m_ev = '0; m_lpps = '0;
    m_hold = '0; m_drop = '0; m_since = '0;
    m_seen = 1'b0; m_armed = 1'b0; m_sync = 1'b0; m_w = 0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour, using the inputs now applied.
  task automatic model_update();
    int   nh;
    bit   full, hit, acc, drp, syn;
    logic [3:0] src;
    nh   = exp_q.size() / 8;
    full = (nh == DEPTH);
    src  = trig & trig_en;
    hit  = (src != 4'd0);
    acc  = hit && (m_hold == 0) && !full;
    drp  = hit && (m_hold == 0) && full;
    syn  = pps && m_armed;
    if (hdr_rd && exp_q.size() > 0) begin
      if (m_w == 7) begin
        repeat (8) void'(exp_q.pop_front());
        m_w = 0;
      end else begin
        m_w++;
      end
    end
    if (acc) begin
      exp_q.push_back(32'h52444531);
      exp_q.push_back(m_ev);
      exp_q.push_back(m_sec);
      exp_q.push_back(m_clk[31:0]);
      exp_q.push_back(info);
      exp_q.push_back({m_since, 4'b0, src, 6'b0, !m_seen, pps});
      exp_q.push_back(m_lpps);
      exp_q.push_back({16'b0, m_clk[47:32]});
    end
    if (acc)              m_hold = holdoff;
    else if (m_hold != 0) m_hold = m_hold - 16'd1;
    m_clk  = m_clk + 48'd1;
    m_sync = syn;
    if (syn) begin
      m_clk = '0; m_sec = '0; m_ev = '0; m_lpps = '0;
      m_drop = '0; m_since = '0; m_seen = 1'b0; m_armed = 1'b0;
    end else begin
      if (pps) begin
        m_lpps = m_clk[31:0] - 32'd1;
        m_sec  = m_sec + 32'd1;
      end
      if (acc) begin
        m_ev = m_ev + 32'd1; m_since = '0; m_seen = 1'b1;
      end
      if (drp) begin
        if (m_drop != 16'hFFFF)  m_drop  = m_drop + 16'd1;
        if (m_since != 16'hFFFF) m_since = m_since + 16'd1;
      end
      if (sync_arm) m_armed = 1'b1;
    end
  endtask

  // Compare every output with the model, then advance one clock.
  task automatic step();
    bit e_valid;
    e_valid = (exp_q.size() > 0);
    chk("valid", 64'(hdr_valid_o), 64'(e_valid));
    chk("dat", 64'(hdr_dat_o), e_valid ? 64'(exp_q[m_w]) : 64'd0);
    chk("last", 64'(hdr_last_o), 64'(e_valid && m_w == 7));
    chk("pending", 64'(pending_o), 64'(exp_q.size() / 8));
    chk("dropped", 64'(dropped_o), 64'(m_drop));
    chk("sync", 64'(sync_o), 64'(m_sync));
    chk("sec", 64'(sec_count_o), 64'(m_sec));
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hdr();
    hdr_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_words[i] = hdr_dat_o;
      rd_last[i]  = hdr_last_o;
      step();
    end
    hdr_rd = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_words[8];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(hdr_valid_o), 64'd0);
    chk("rst_dat", 64'(hdr_dat_o), 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_sec", 64'(sec_count_o), 64'd0);
    chk("rst_sync", 64'(sync_o), 64'd0);
    rst_n = 1'b1;

    // single event at clk_cnt = 100
    while (m_clk != 48'd100) step();
    trig = 4'b0001;
    info = $urandom;
    saved_info = info;
    step();
    trig = '0;
    chk("t1_valid", 64'(hdr_valid_o), 64'd1);
    read_hdr();
    exp_words = '{32'h52444531, 32'd0, 32'd0, 32'd100, saved_info, 32'h00000102, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_word%0d", i), 64'(rd_words[i]), 64'(exp_words[i]));
      chk($sformatf("t1_last%0d", i), 64'(rd_last[i]), 64'(i == 7));
    end

    // masking
    trig_en = 4'b1110;
    trig = 4'b0001;
    repeat (3) step();
    chk("mask_blocked", 64'(pending_o), 64'd0);
    trig = 4'b0110;
    step();
    trig = '0;
    step();
    chk("mask_pending", 64'(pending_o), 64'd1);
    read_hdr();
    chk("mask_field", 64'(rd_words[5][15:8]), 64'h06);
    chk("mask_first", 64'(rd_words[5][1]), 64'd0);
    trig_en = 4'hF;

    // holdoff
    holdoff = 16'd10;
    trig = 4'b0001;
    repeat (30) step();
    trig = '0;
    holdoff = '0;
    chk("hold_pending", 64'(pending_o), 64'd3);
    chk("hold_dropped", 64'(dropped_o), 64'd0);
    for (int h = 0; h < 3; h++) begin
      read_hdr();
      w3[h] = rd_words[3];
    end
    chk("hold_delta1", 64'(w3[1] - w3[0]), 64'd11);
    chk("hold_delta2", 64'(w3[2] - w3[1]), 64'd11);

    // overflow and counted drops
    for (int i = 0; i < DEPTH + 3; i++) begin
      trig = 4'b0010;
      step();
      trig = '0;
      step();
      step();
    end
    chk("ovf_pending", 64'(pending_o), 64'(DEPTH));
    chk("ovf_dropped", 64'(dropped_o), 64'd3);
    read_hdr();
    trig = 4'b0010;
    step();
    trig = '0;
    step();
    for (int h = 0; h < DEPTH; h++) read_hdr();
    chk("ovf_since", 64'(rd_words[5][31:16]), 64'd3);
    chk("ovf_dropped_kept", 64'(dropped_o), 64'd3);

    // PPS and armed sync
    pps = 1'b1;
    step();
    pps = 1'b0;
    chk("pps_sec1", 64'(sec_count_o), 64'd1);
    sync_arm = 1'b1;
    step();
    sync_arm = 1'b0;
    repeat (49) step();
    pps = 1'b1;
    step();
    pps = 1'b0;
    chk("sync_pulse", 64'(sync_o), 64'd1);
    chk("sync_sec", 64'(sec_count_o), 64'd0);
    chk("sync_dropped", 64'(dropped_o), 64'd0);
    trig = 4'b0100;
    step();
    trig = '0;
    chk("sync_pulse_end", 64'(sync_o), 64'd0);
    read_hdr();
    chk("sync_ev", 64'(rd_words[1]), 64'd0);
    chk("sync_clk", 64'(rd_words[3]), 64'd0);
    chk("sync_first", 64'(rd_words[5][1]), 64'd1);
    chk("sync_lpps", 64'(rd_words[6]), 64'd0);
    sec_before = sec_count_o;
    pps = 1'b1;
    step();
    pps = 1'b0;
    chk("pps_inc", 64'(sec_count_o), 64'(sec_before + 32'd1));

    // random traffic
    for (int c = 0; c < 400; c++) begin
      trig     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      trig_en  = 4'($urandom_range(0, 15));
      holdoff  = 16'($urandom_range(0, 4));
      info     = $urandom;
      hdr_rd   = 1'($urandom_range(0, 1));
      pps      = ($urandom_range(0, 39) == 0);
      sync_arm = ($urandom_range(0, 59) == 0);
      step();
    end
    trig = '0; pps = 1'b0; sync_arm = 1'b0; trig_en = 4'hF; holdoff = '0;
    hdr_rd = 1'b1;
    repeat (DEPTH * 8 + 8) step();
    hdr_rd = 1'b0;
    chk("drain_empty", 64'(hdr_valid_o), 64'd0);

    // asynchronous reset mid-header
    trig = 4'b1000;
    repeat (2) step();
    trig = '0;
    step();
    hdr_rd = 1'b1;
    repeat (3) step();
    hdr_rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(hdr_valid_o), 64'd0);
    chk("arst_pending", 64'(pending_o), 64'd0);
    chk("arst_dat", 64'(hdr_dat_o), 64'd0);
    chk("arst_last", 64'(hdr_last_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step();

    // 32-bit boundary of clk_cnt on the preset instance
    while (m_clk != 48'd5) step();
    w_trig = 4'b0001;
    w_exp0 = W_PRESET + 64'(m_clk);
    step();
    w_exp1 = W_PRESET + 64'(m_clk);
    step();
    w_trig = '0;
    step();
    chk("w_valid", 64'(w_valid), 64'd1);
    chk("w_pending", 64'(w_pending), 64'd2);
    w_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_words[i] = w_dat;
      w_lasts[i] = w_last;
      step();
    end
    w_rd = 1'b0;
    chk("w_id", 64'(w_words[8]), 64'h52444531);
    chk("w_lo_a", 64'(w_words[3]), 64'(w_exp0[31:0]));
    chk("w_hi_a", 64'(w_words[7]), 64'(w_exp0[47:32]));
    chk("w_lo_b", 64'(w_words[11]), 64'd0);
    chk("w_hi_b", 64'(w_words[15]), 64'd1);
    chk("w_last6", 64'(w_lasts[6]), 64'd0);
    chk("w_last7", 64'(w_lasts[7]), 64'd1);
    chk("w_empty", 64'(w_valid), 64'd0);
    chk("w_pending_end", 64'(w_pending), 64'd0);
    chk("w_dropped", 64'(w_dropped), 64'd0);
    chk("w_sync", 64'(w_sync), 64'd0);
    chk("w_sec", 64'(w_sec), 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
